// File: rtl/datapath_sequencer_pkg.sv
// datapath_sequencer_pkg: state codes, opcode/funct constants and datapath select encodings
package datapath_sequencer_pkg;
  typedef enum logic [4:0] {
    S_RST, S_FETCH0, S_FETCH_WAIT, S_FETCH2, S_DECODE, S_EXEC_R, S_R_WB, S_ADDI_EX, S_ADDI_WB,
    S_ADDR, S_LW_RD, S_LW_WAIT, S_LW_WB, S_SW_WR, S_BEQ, S_JUMP, S_JR, S_ILLEGAL
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_XOR = 6'h26;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_A = 2'b01;
  localparam logic [2:0] SRCB_B = 3'b000, SRCB_4 = 3'b001, SRCB_IMM = 3'b010, SRCB_IMM_SH = 3'b011;
  localparam logic [2:0] SRCB_A = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01;
  function automatic logic [31:0] alu_b_mux(input logic [2:0] sel, input logic [31:0] b,
                                            input logic [31:0] imm, input logic [31:0] a);
    return sel == SRCB_B ? b : sel == SRCB_4 ? 32'd4 : sel == SRCB_IMM ? imm :
           sel == SRCB_IMM_SH ? (imm << 2) : sel == SRCB_A ? a : '0;
  endfunction
endpackage

// File: rtl/datapath_sequencer_alu_funct_decoder.sv
// alu_funct_decoder: maps R-type funct to alu_op and flags unsupported functs
module alu_funct_decoder
  import datapath_sequencer_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_valid
);
  always_comb begin
    o_alu_op = i_funct == F_ADD ? ALU_ADD : i_funct == F_SUB ? ALU_SUB :
               i_funct == F_AND ? ALU_AND : i_funct == F_XOR ? ALU_XOR : ALU_PASS;
    o_valid = i_funct == F_ADD || i_funct == F_SUB || i_funct == F_AND || i_funct == F_XOR;
  end
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multicycle MIPS-style control FSM with configurable memory wait states
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [4:0] state_out
);
  localparam logic [2:0] W_LOAD = 3'(MEM_WAIT - 1);
  state_t     r_state, w_dispatch;
  logic [2:0] r_cnt, w_fop;
  logic       r_illegal, w_fvalid;
  alu_funct_decoder u_dec (.i_funct(funct), .o_alu_op(w_fop), .o_valid(w_fvalid));
  assign w_dispatch = opcode == OP_R ? (funct == F_JR ? S_JR : S_EXEC_R) :
                      opcode == OP_ADDI ? S_ADDI_EX :
                      (opcode == OP_LW || opcode == OP_SW) ? S_ADDR :
                      opcode == OP_BEQ ? S_BEQ : opcode == OP_J ? S_JUMP : S_ILLEGAL;
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_RST;
      r_cnt <= '0;
      r_illegal <= 1'b0;
    end else
      case (r_state)
        S_RST: r_state <= S_FETCH0;
        S_FETCH0: begin
          r_state <= S_FETCH_WAIT;
          r_cnt <= W_LOAD;
        end
        S_FETCH_WAIT: if (r_cnt == 3'd0) r_state <= S_FETCH2; else r_cnt <= r_cnt - 3'd1;
        S_FETCH2: r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= w_dispatch;
          r_illegal <= w_dispatch == S_ILLEGAL;
        end
        S_EXEC_R: begin
          r_state <= w_fvalid ? S_R_WB : S_ILLEGAL;
          r_illegal <= !w_fvalid;
        end
        S_ADDI_EX: r_state <= S_ADDI_WB;
        S_ADDR: r_state <= opcode == OP_LW ? S_LW_RD : S_SW_WR;
        S_LW_RD: begin
          r_state <= S_LW_WAIT;
          r_cnt <= W_LOAD;
        end
        S_LW_WAIT: if (r_cnt == 3'd0) r_state <= S_LW_WB; else r_cnt <= r_cnt - 3'd1;
        S_ILLEGAL: r_state <= S_ILLEGAL;
        default: r_state <= S_FETCH0;
      endcase
  always_comb begin
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_B;
    alu_op = ALU_PASS;
    pc_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    iord = 1'b0;
    ir_write = 1'b0;
    mdr_write = 1'b0;
    aluout_write = 1'b0;
    reg_write = 1'b0;
    reg_dst = RD_RT;
    mem_to_reg = M2R_ALUOUT;
    pc_source = PCS_ALU;
    case (r_state)
      S_FETCH0: begin
        mem_read = 1'b1;
        alu_src_b = SRCB_4;
        alu_op = ALU_ADD;
        pc_write = 1'b1;
      end
      S_FETCH_WAIT: mem_read = 1'b1;
      S_FETCH2: ir_write = 1'b1;
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op = ALU_ADD;
        aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_A;
        alu_op = w_fop;
        aluout_write = 1'b1;
      end
      S_R_WB: begin
        reg_dst = RD_RD;
        reg_write = 1'b1;
      end
      S_ADDI_EX, S_ADDR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op = ALU_ADD;
        aluout_write = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_LW_RD: begin
        iord = 1'b1;
        mem_read = 1'b1;
      end
      S_LW_WAIT: begin
        iord = 1'b1;
        mem_read = 1'b1;
        mdr_write = r_cnt == 3'd0;
      end
      S_LW_WB: begin
        mem_to_reg = M2R_MDR;
        reg_write = 1'b1;
      end
      S_SW_WR: begin
        iord = 1'b1;
        mem_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_A;
        alu_op = ALU_SUB;
        pc_source = PCS_ALUOUT;
        pc_write = zero;
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write = 1'b1;
      end
      S_JR: begin
        alu_src_a = SRCA_A;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  assign illegal_op = r_illegal;
  assign state_out = r_state;
endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, memory wait cycles inserted after every memory read (range 1..7).
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the IR.
REQ-005 SHALL have port funct, input, 6, instruction bits [5:0] from the IR.
REQ-006 SHALL have port zero, input, 1, ALU zero flag of the current cycle.
REQ-007 SHALL have port alu_src_a, output, 2: 00 PC, 01 A.
REQ-008 SHALL have port alu_src_b, output, 3: 000 B, 001 constant 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 A.
REQ-009 SHALL have port alu_op, output, 3: 000 pass A, 001 ADD, 010 SUB, 011 AND, 110 XOR.
REQ-010 SHALL have output strobes, 1 bit each: pc_write, mem_read, mem_write, iord, ir_write, mdr_write, aluout_write, reg_write.
REQ-011 SHALL have ports reg_dst, output, 2 (00 rt, 01 rd); mem_to_reg, output, 2 (00 ALUOut, 01 MDR); pc_source, output, 2 (00 ALU result, 01 ALUOut, 10 jump target).
REQ-012 SHALL have port illegal_op, output, 1, sticky unsupported-opcode flag; state_out, output, 5, current state code.

Function
REQ-013 SHALL be a Moore FSM; all outputs registered-state decoded, except pc_write, which SHALL be Mealy on zero in BEQ only.
REQ-014 Outputs not listed for a state SHALL be 0 / 00 / 000.
REQ-015 RST: all outputs 0; next FETCH0.
REQ-016 FETCH0: mem_read, alu_src_a=00, alu_src_b=001, alu_op=ADD, pc_source=00, pc_write; next FETCH_WAIT.
REQ-017 FETCH_WAIT: mem_read held; wait counter loaded with MEM_WAIT-1 on entry, decrements each cycle; exit to FETCH2 when counter==0.
REQ-018 FETCH2: ir_write; next DECODE.
REQ-019 DECODE: alu_src_a=00, alu_src_b=011, alu_op=ADD, aluout_write; dispatch: R with funct 0x08 -> JR, R otherwise -> EXEC_R, 0x08 -> ADDI_EX, 0x23/0x2B -> ADDR, 0x04 -> BEQ, 0x02 -> JUMP, else ILLEGAL.
REQ-020 EXEC_R: alu_src_a=01, alu_src_b=000, alu_op from funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR), aluout_write; unsupported funct -> ILLEGAL instead; else next R_WB.
REQ-021 R_WB: reg_dst=01, mem_to_reg=00, reg_write; next FETCH0.
REQ-022 ADDI_EX: alu_src_a=01, alu_src_b=010, ADD, aluout_write -> ADDI_WB: reg_dst=00, mem_to_reg=00, reg_write -> FETCH0.
REQ-023 ADDR: alu_src_a=01, alu_src_b=010, ADD, aluout_write; lw -> LW_RD, sw -> SW_WR.
REQ-024 LW_RD: iord, mem_read -> LW_WAIT: iord, mem_read, wait counter as REQ-017, mdr_write on the exit cycle -> LW_WB: reg_dst=00, mem_to_reg=01, reg_write -> FETCH0.
REQ-025 SW_WR: iord, mem_write -> FETCH0.
REQ-026 BEQ: alu_src_a=01, alu_src_b=000, SUB, pc_source=01; pc_write = zero; next FETCH0.
REQ-027 JUMP: pc_source=10, pc_write -> FETCH0; JR: alu_src_a=01, alu_op=000, pc_source=00, pc_write -> FETCH0.
REQ-028 ILLEGAL: illegal_op=1, all strobes 0; SHALL remain until reset.
REQ-029 Cycle counts at MEM_WAIT=1: R/addi/sw 6, lw 8, beq/j/jr 5.

Reset
REQ-030 reset sampled high SHALL force state RST, counter 0, illegal_op 0 on that edge, from any state including mid-wait.
REQ-031 reset held high SHALL keep RST; first rising edge with reset low SHALL move to FETCH0.

Structure
REQ-032 Shared package SHALL hold state codes, opcode/funct constants, alu_src_a/alu_src_b/alu_op/pc_source encodings; the operand-B mux SHALL use the same alu_src_b constants.
REQ-033 One sub-module alu_funct_decoder (funct -> alu_op, valid) SHALL be instantiated for EXEC_R.

Verification
REQ-034 reset 2 cycles, then opcode 0x00/funct 0x20 -> FETCH0 first cycle after release, reg_write with reg_dst=01 in cycle 6, back in FETCH0 cycle 7.
REQ-035 lw (0x23), MEM_WAIT=3 -> mdr_write on 3rd LW_WAIT cycle, reg_write with mem_to_reg=01 next cycle, 12 cycles total.
REQ-036 beq (0x04) with zero=1 -> pc_write=1, pc_source=01 in BEQ; zero=0 -> pc_write=0; both return to FETCH0.
REQ-037 opcode 0x3F -> illegal_op=1 from cycle after DECODE, held 20 cycles; reset clears it and restarts at FETCH0.
REQ-038 reset asserted during LW_WAIT -> RST next edge, all strobes 0, no reg_write ever issued for that lw.
REQ-039 Every state: alu_src_b matches REQ-016..027 (001 in FETCH0, 011 in DECODE, 010 in ADDR/ADDI_EX, 000 in EXEC_R/BEQ).
